// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the dual-input frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Brings one asynchronous frequency input into the CLK domain and flags its rising edges.
module edge_sync
    import freq_meter_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic D,
    output logic EDGE
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], D};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign EDGE = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Counts F0/F1 rising edges over a GATE_CYCLES window and publishes both counts.
// Optional signed CNT0-CNT1 output DIFF is built when FREQ_DIFF_EN is defined.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int GATE_W      = 16
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    EN,
    input  logic                    F0,
    input  logic                    F1,
    output logic [CNT_W-1:0]        CNT0,
    output logic [CNT_W-1:0]        CNT1,
    output logic                    F0_GT_F1,
    output logic                    OVF,
`ifdef FREQ_DIFF_EN
    output logic signed [CNT_W:0]   DIFF,
`endif
    output logic                    VALID
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    state_t r_state;
    state_t w_state_next;

    logic [GATE_W-1:0]          r_gate;
    logic                       w_terminal;
    logic                       w_clr_work;
    logic                       w_count;
    logic                       w_load_gate;
    logic                       w_publish;

    logic [1:0]                 w_f;
    logic [1:0]                 w_edge;
    logic [1:0][CNT_W-1:0]      w_cnt_final;
    logic [1:0]                 w_ovf_final;

    logic [CNT_W-1:0]           r_cnt0_out;
    logic [CNT_W-1:0]           r_cnt1_out;
    logic                       r_gt_out;
    logic                       r_ovf_out;
    logic                       r_valid;

    assign w_f        = {F1, F0};
    assign w_terminal = (r_state == GATE) && (r_gate == '0);

    // Per-channel synchronizer and saturating working counter with sticky overflow.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic             w_sat;

            edge_sync u_edge_sync (
                .CLK  (CLK),
                .CLR  (CLR),
                .D    (w_f[gi]),
                .EDGE (w_edge[gi])
            );

            assign w_sat           = (r_cnt == CNT_MAX);
            assign w_cnt_final[gi] = (w_edge[gi] && !w_sat) ? r_cnt + 1'b1 : r_cnt;
            assign w_ovf_final[gi] = r_ovf | (w_edge[gi] & w_sat);

            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_clr_work) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_count) begin
                    r_cnt <= w_cnt_final[gi];
                    r_ovf <= w_ovf_final[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = EN ? ARM : IDLE;
            ARM:     w_state_next = EN ? GATE : IDLE;
            GATE:    w_state_next = EN ? GATE : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A terminal cycle reloads counters to zero, so the next window's first edge counts as 1.
    always_comb begin
        w_clr_work  = 1'b1;
        w_count     = 1'b0;
        w_load_gate = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            ARM: begin
                w_load_gate = 1'b1;
            end
            GATE: begin
                w_clr_work  = w_terminal;
                w_count     = ~w_terminal;
                w_load_gate = w_terminal;
                w_publish   = w_terminal;
            end
            default: begin
                w_clr_work = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_gate <= '0;
        end else if (w_load_gate) begin
            r_gate <= GATE_LOAD;
        end else if (r_state == GATE) begin
            r_gate <= r_gate - 1'b1;
        end else begin
            r_gate <= '0;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cnt0_out <= '0;
            r_cnt1_out <= '0;
            r_gt_out   <= 1'b0;
            r_ovf_out  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_cnt0_out <= w_cnt_final[0];
                r_cnt1_out <= w_cnt_final[1];
                r_gt_out   <= (w_cnt_final[0] > w_cnt_final[1]);
                r_ovf_out  <= |w_ovf_final;
            end
        end
    end

`ifdef FREQ_DIFF_EN
    logic signed [CNT_W:0] r_diff_out;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_diff_out <= '0;
        end else if (w_publish) begin
            r_diff_out <= $signed({1'b0, w_cnt_final[0]}) - $signed({1'b0, w_cnt_final[1]});
        end
    end

    assign DIFF = r_diff_out;
`endif

    assign CNT0     = r_cnt0_out;
    assign CNT1     = r_cnt1_out;
    assign F0_GT_F1 = r_gt_out;
    assign OVF      = r_ovf_out;
    assign VALID    = r_valid;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: edge counts per window are derived from the sampled inputs.
module tb_freq_meter;

    localparam int GC   = 100;
    localparam int CW   = 16;
    localparam int CW4  = 4;
    localparam int MAXC = 16384;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    logic EN  = 1'b0;
    logic F0  = 1'b0;
    logic F1  = 1'b0;

    logic [CW-1:0]  cnt0, cnt1;
    logic           gt, ovf, valid;
    logic [CW4-1:0] cnt0_4, cnt1_4;
    logic           gt4, ovf4, valid4;
`ifdef FREQ_DIFF_EN
    logic signed [CW:0]  diff;
    logic signed [CW4:0] diff4;
`endif

    freq_meter #(.CNT_W(CW), .GATE_CYCLES(GC), .GATE_W(16)) u_dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .F0(F0), .F1(F1),
        .CNT0(cnt0), .CNT1(cnt1), .F0_GT_F1(gt), .OVF(ovf),
`ifdef FREQ_DIFF_EN
        .DIFF(diff),
`endif
        .VALID(valid)
    );

    freq_meter #(.CNT_W(CW4), .GATE_CYCLES(GC), .GATE_W(16)) u_dut4 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .F0(F0), .F1(F1),
        .CNT0(cnt0_4), .CNT1(cnt1_4), .F0_GT_F1(gt4), .OVF(ovf4),
`ifdef FREQ_DIFF_EN
        .DIFF(diff4),
`endif
        .VALID(valid4)
    );

    typedef struct {
        int c;
        int c0, c1, d;
        bit g, o;
        bit v4;
        int c40, c41, d4;
        bit g4, o4;
    } rec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   s0 [MAXC];
    bit   s1 [MAXC];
    int   per0 = 0, per1 = 0, ph0 = 0, ph1 = 0;
    int   last0 = 0, last1 = 0;
    rec_t vq [$];

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Input samples as seen at each rising edge, indexed by edge number.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            s0[cyc] = F0;
            s1[cyc] = F1;
        end
    end

    // Square waves of period perN (high perN/2 cycles), 1 = random bits, 0 = held low.
    always @(posedge CLK) begin
        #1;
        if (per0 >= 2) begin ph0 = (ph0 + 1) % per0; F0 = (ph0 < per0 / 2); end
        else if (per0 == 1) F0 = 1'($urandom_range(0, 1));
        else F0 = 1'b0;
        if (per1 >= 2) begin ph1 = (ph1 + 1) % per1; F1 = (ph1 < per1 / 2); end
        else if (per1 == 1) F1 = 1'($urandom_range(0, 1));
        else F1 = 1'b0;
    end

    always @(negedge CLK) begin
        if (valid) begin
            rec_t r;
            r.c   = cyc;
            r.c0  = int'(cnt0);
            r.c1  = int'(cnt1);
            r.g   = gt;
            r.o   = ovf;
            r.v4  = valid4;
            r.c40 = int'(cnt0_4);
            r.c41 = int'(cnt1_4);
            r.g4  = gt4;
            r.o4  = ovf4;
`ifdef FREQ_DIFF_EN
            r.d   = int'(diff);
            r.d4  = int'(diff4);
`else
            r.d   = 0;
            r.d4  = 0;
`endif
            vq.push_back(r);
        end
    end

    // A rise is counted at edge p when it was sampled low at p-3 and high at p-2.
    function automatic int edges(input bit ch, input int a, input int b);
        int n = 0;
        for (int p = a; p <= b; p++) begin
            if (ch ? (s1[p-2] && !s1[p-3]) : (s0[p-2] && !s0[p-3])) n++;
        end
        return n;
    endfunction

    task automatic check_window(input int e, input int w);
        int   a, b, n0, n1, x0, x1, y0, y1;
        rec_t r;
        a  = e + 2 + GC * w;
        b  = a + GC - 1;
        n0 = edges(1'b0, a, b);
        n1 = edges(1'b1, a, b);
        x0 = (n0 > 65535) ? 65535 : n0;
        x1 = (n1 > 65535) ? 65535 : n1;
        y0 = (n0 > 15) ? 15 : n0;
        y1 = (n1 > 15) ? 15 : n1;
        check("valid_seen", longint'(vq.size() > 0), 1);
        if (vq.size() > 0) begin
            r = vq.pop_front();
            $display("[TB] window start=%0d w=%0d cnt0=%0d cnt1=%0d gt=%0d ovf=%0d cnt0_4=%0d cnt1_4=%0d ovf4=%0d",
                     a, w, r.c0, r.c1, r.g, r.o, r.c40, r.c41, r.o4);
            check("valid_cycle", r.c, b);
            check("cnt0", r.c0, x0);
            check("cnt1", r.c1, x1);
            check("f0_gt_f1", r.g, longint'(x0 > x1));
            check("ovf", r.o, longint'(n0 > 65535 || n1 > 65535));
            check("valid_w4", r.v4, 1);
            check("cnt0_w4", r.c40, y0);
            check("cnt1_w4", r.c41, y1);
            check("f0_gt_f1_w4", r.g4, longint'(y0 > y1));
            check("ovf_w4", r.o4, longint'(n0 > 15 || n1 > 15));
`ifdef FREQ_DIFF_EN
            check("diff", r.d, x0 - x1);
            check("diff_w4", r.d4, y0 - y1);
`endif
        end
        last0 = x0;
        last1 = x1;
    endtask

    task automatic start_en(output int e);
        @(posedge CLK); #1;
        EN = 1'b1;
        e  = cyc + 1;
    endtask

    task automatic wait_until(input int target);
        do begin
            @(posedge CLK); #1;
        end while (cyc < target);
    endtask

    // EN falls so that it is sampled low exactly at the last window's terminal cycle.
    task automatic run(input int p0, input int p1, input int nwin);
        int e;
        per0 = p0;
        per1 = p1;
        repeat (4) @(posedge CLK);
        start_en(e);
        wait_until(e + GC * nwin);
        EN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int w = 0; w < nwin; w++) check_window(e, w);
        check("no_extra_valid", vq.size(), 0);
        vq.delete();
    endtask

    initial begin
        int e;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_gt", gt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", valid, 0);
        check("rst_cnt0_w4", cnt0_4, 0);
        CLR = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("idle_no_valid", vq.size(), 0);

        run(4, 10, 1);
        run(5, 5, 5);
        run(2, 3, 1);
        run(0, 0, 1);

        // Abort mid-window: results must hold and no VALID may appear.
        run(4, 10, 1);
        start_en(e);
        wait_until(e + 51);
        EN = 1'b0;
        repeat (250) @(posedge CLK);
        #1;
        $display("[TB] abort cnt0=%0d cnt1=%0d pending_valid=%0d", cnt0, cnt1, vq.size());
        check("abort_no_valid", vq.size(), 0);
        check("abort_cnt0_hold", cnt0, last0);
        check("abort_cnt1_hold", cnt1, last1);
        vq.delete();

        // Asynchronous clear mid-window.
        start_en(e);
        wait_until(e + 41);
        CLR = 1'b1;
        EN  = 1'b0;
        #1;
        $display("[TB] clr cnt0=%0d cnt1=%0d gt=%0d ovf=%0d valid=%0d", cnt0, cnt1, gt, ovf, valid);
        check("clr_cnt0", cnt0, 0);
        check("clr_cnt1", cnt1, 0);
        check("clr_gt", gt, 0);
        check("clr_ovf", ovf, 0);
        check("clr_valid", valid, 0);
        check("clr_cnt0_w4", cnt0_4, 0);
        @(posedge CLK); #1;
        CLR = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("clr_no_valid", vq.size(), 0);
        vq.delete();
        run(4, 10, 1);
        run(10, 4, 1);

        for (int i = 0; i < 4; i++) begin
            run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
